slave_mem: RTL and testbench

SLAVE_MEM -- requirements
Module: slave_mem

---
 rtl/slave_mem.sv | 111 +++++++++++
 tb/tb_slave_mem.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/slave_mem.sv
// Slave write port with a configurable wait-state handshake and an 8x3 register array.
// A debug read port returns mem[rd_addr] with one cycle of latency.
module slave_mem (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [2:0] addr_in,
    input  logic [2:0] value_in,
    input  logic [1:0] wait_cfg,
    input  logic [2:0] rd_addr,
    output logic       ready,
    output logic [2:0] rd_data,
    output logic [7:0] wr_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    state_t     r_state;
    logic [1:0] r_wait_cnt;
    logic       r_ready;
    logic       r_busy;
    logic [2:0] r_mem [0:7];
    logic [2:0] r_rd_data;
    logic [7:0] r_wr_count;
    logic       w_handshake;

    assign w_handshake = (r_state == S_ACK) && valid;

    // ready/busy are registered alongside the state so they decode the next state directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_busy <= 1'b1;
                        if (wait_cfg == 2'd0) begin
                            r_state <= S_ACK;
                            r_ready <= 1'b1;
                        end else begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= wait_cfg;
                            r_ready    <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 2'd1) begin
                        r_state    <= S_ACK;
                        r_wait_cnt <= '0;
                        r_ready    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                S_ACK: begin
                    r_ready <= 1'b0;
                    if (valid) begin
                        r_state <= S_HOLD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= '0;
                    r_ready    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Read samples the array before this edge's write lands, giving old data on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem      <= '{default: '0};
            r_rd_data  <= '0;
            r_wr_count <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
            if (w_handshake) begin
                r_mem[addr_in] <= value_in;
                r_wr_count     <= r_wr_count + 8'd1;
            end
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign rd_data  = r_rd_data;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_slave_mem.sv
// Directed self-checking bench for slave_mem: handshake timing, wait states,
// read/write collision, asynchronous abort and write-counter wrap.
module tb_slave_mem;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [2:0] addr_in;
    logic [2:0] value_in;
    logic [1:0] wait_cfg;
    logic [2:0] rd_addr;
    logic       ready;
    logic [2:0] rd_data;
    logic [7:0] wr_count;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    slave_mem dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .addr_in  (addr_in),
        .value_in (value_in),
        .wait_cfg (wait_cfg),
        .rd_addr  (rd_addr),
        .ready    (ready),
        .rd_data  (rd_data),
        .wr_count (wr_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [2:0] v, input logic [1:0] w);
        bit seen;
        seen     = 1'b0;
        addr_in  = a;
        value_in = v;
        wait_cfg = w;
        valid    = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = ready;
        end
        if (!seen) check("write_timeout", 0, 1);
        tick();
        valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        valid    = 1'b0;
        addr_in  = '0;
        value_in = '0;
        wait_cfg = '0;
        rd_addr  = '0;
        tick();
        tick();
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_count", wr_count, 0);
        rst_n = 1'b1;
        tick();

        // Zero wait states: ready for exactly one cycle, then HOLD.
        addr_in = 3'd5; value_in = 3'd3; wait_cfg = 2'd0; valid = 1'b1;
        tick();
        check("w0_ready_t1", ready, 1);
        check("w0_busy_t1", busy, 1);
        tick();
        check("w0_ready_hold", ready, 0);
        check("w0_busy_hold", busy, 1);
        check("w0_wr_count", wr_count, 1);
        valid = 1'b0; rd_addr = 3'd5;
        tick();
        check("w0_busy_idle", busy, 0);
        check("w0_rd_data", rd_data, 3);

        // Three wait states; wait_cfg changed mid-WAIT must not shorten it.
        addr_in = 3'd6; value_in = 3'd5; wait_cfg = 2'd3; valid = 1'b1;
        tick();
        check("w3_ready_t1", ready, 0);
        check("w3_busy_t1", busy, 1);
        wait_cfg = 2'd0;
        tick();
        check("w3_ready_t2", ready, 0);
        tick();
        check("w3_ready_t3", ready, 0);
        tick();
        check("w3_ready_t4", ready, 1);
        tick();
        check("w3_ready_hold", ready, 0);
        check("w3_wr_count", wr_count, 2);
        tick();
        check("w3_ready_after_hold", ready, 0);
        check("w3_busy_after_hold", busy, 0);
        valid = 1'b0; rd_addr = 3'd6;
        tick();
        check("w3_no_double_write", wr_count, 2);
        check("w3_rd_data", rd_data, 5);

        // ACK with valid dropped returns to IDLE without writing.
        addr_in = 3'd0; value_in = 3'd7; wait_cfg = 2'd1; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        check("abandon_ready", ready, 1);
        tick();
        check("abandon_ready_low", ready, 0);
        check("abandon_busy", busy, 0);
        check("abandon_wr_count", wr_count, 2);
        rd_addr = 3'd0;
        tick();
        check("abandon_mem0", rd_data, 0);

        // Back-to-back requests with valid held throughout.
        pulse_reset();
        addr_in = 3'd1; value_in = 3'd7; wait_cfg = 2'd0; valid = 1'b1;
        tick();
        check("b2b_ready1", ready, 1);
        tick();
        check("b2b_low_a", ready, 0);
        addr_in = 3'd2; value_in = 3'd4;
        tick();
        check("b2b_low_b", ready, 0);
        tick();
        check("b2b_ready2", ready, 1);
        tick();
        check("b2b_low_c", ready, 0);
        valid = 1'b0;
        tick();
        check("b2b_wr_count", wr_count, 2);
        rd_addr = 3'd1;
        tick();
        check("b2b_mem1", rd_data, 7);
        rd_addr = 3'd2;
        tick();
        check("b2b_mem2", rd_data, 4);

        // Read/write collision returns pre-write data on the write edge.
        rd_addr = 3'd4;
        do_write(3'd4, 3'd2, 2'd0);
        check("coll_pre", rd_data, 2);
        addr_in = 3'd4; value_in = 3'd6; wait_cfg = 2'd0; valid = 1'b1;
        tick();
        check("coll_ack_ready", ready, 1);
        tick();
        check("coll_write_edge", rd_data, 2);
        valid = 1'b0;
        tick();
        check("coll_next", rd_data, 6);

        // Reset pulsed during WAIT aborts immediately with no write.
        addr_in = 3'd3; value_in = 3'd7; wait_cfg = 2'd3; valid = 1'b1;
        tick();
        tick();
        check("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 0);
        check("abort_busy", busy, 0);
        check("abort_wr_count", wr_count, 0);
        check("abort_rd_data", rd_data, 0);
        valid = 1'b0;
        #1;
        rst_n = 1'b1;
        rd_addr = 3'd3;
        tick();
        check("abort_mem3", rd_data, 0);
        rd_addr = 3'd4;
        tick();
        check("abort_mem4", rd_data, 0);

        // First transaction after reset matches power-up behaviour.
        addr_in = 3'd3; value_in = 3'd7; wait_cfg = 2'd0; valid = 1'b1;
        tick();
        check("post_rst_ready", ready, 1);
        tick();
        valid = 1'b0;
        check("post_rst_wr_count", wr_count, 1);

        // Counter wrap: 255 more writes bring the total to 256.
        for (int i = 0; i < 254; i++) begin
            do_write(3'(i), 3'(i + 1), 2'(i));
        end
        check("wrap_255", wr_count, 255);
        do_write(3'd7, 3'd1, 2'd0);
        check("wrap_0", wr_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
